// File: rtl/usb_rx_phy.sv
// USB receive front end: pad synchroniser, DPLL bit recovery, NRZI decode,
// bit-unstuffing, SYNC/EOP framing and bus-reset detection.
module usb_rx_phy #(
    parameter int OVERSAMPLE   = 4,
    parameter int RESET_CYCLES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] d_i,
    input  logic       rx_en,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error,
    output logic       usb_reset
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam logic [1:0]    LS_J         = 2'b10;
    localparam logic [1:0]    LS_K         = 2'b01;
    localparam logic [1:0]    LS_SE0       = 2'b00;
    localparam logic [1:0]    LS_SE1       = 2'b11;
    localparam logic [PW-1:0] SAMPLE_PHASE = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] RESET_MAX    = CW'(RESET_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] se0_cnt_q, se0_cnt_d;
    logic [2:0]    zero_cnt_q, zero_cnt_d, ones_cnt_q, ones_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d, j_cnt_q, j_cnt_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          valid_q, valid_d, error_q, error_d, se0_seen_q, se0_seen_d;
    logic          sample, is_j, is_k, is_se0, is_se1, is_jk, dec_bit;

    assign is_j    = (sync2_q == LS_J);
    assign is_k    = (sync2_q == LS_K);
    assign is_se0  = (sync2_q == LS_SE0);
    assign is_se1  = (sync2_q == LS_SE1);
    assign is_jk   = is_j | is_k;
    assign sample  = (phase_q == SAMPLE_PHASE);
    assign dec_bit = (sync2_q == prev_q);

    // Front end: synchroniser, DPLL phase, NRZI history and SE0 timer
    always_comb begin
        sync1_d   = d_i;
        sync2_d   = sync1_q;
        phase_d   = (sync1_q != sync2_q) ? '0 : phase_q + PW'(1);
        prev_d    = (sample && is_jk) ? sync2_q : prev_q;
        se0_cnt_d = '0;
        if (is_se0) begin
            se0_cnt_d = (se0_cnt_q == RESET_MAX) ? se0_cnt_q : se0_cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = S_IDLE;
        end else if (sample) begin
            unique case (state_q)
                S_IDLE:  if (is_k) state_d = S_SYNC;
                S_SYNC: begin
                    if (!is_jk)      state_d = S_IDLE;
                    else if (dec_bit) state_d = (zero_cnt_q >= 3'd5) ? S_DATA : S_IDLE;
                end
                S_DATA: begin
                    if (is_se0)                          state_d = S_EOP;
                    else if (is_se1)                     state_d = S_ERROR;
                    else if (ones_cnt_q == 3'd6 && dec_bit) state_d = S_ERROR;
                end
                S_EOP: begin
                    if (is_j)               state_d = S_IDLE;
                    else if (is_k || is_se1) state_d = S_ERROR;
                end
                S_ERROR: if (is_j && (se0_seen_q || j_cnt_q == 3'd7)) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs and receive datapath
    always_comb begin
        rx_active  = (state_q == S_DATA) || (state_q == S_EOP) || (state_q == S_ERROR);
        zero_cnt_d = zero_cnt_q;
        ones_cnt_d = ones_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        se0_seen_d = (state_q == S_ERROR) ? se0_seen_q : 1'b0;
        j_cnt_d    = (state_q == S_ERROR) ? j_cnt_q : 3'd0;
        if (!rx_en) begin
            zero_cnt_d = '0;
            ones_cnt_d = '0;
            bit_cnt_d  = '0;
            se0_seen_d = 1'b0;
            j_cnt_d    = '0;
        end else if (sample) begin
            unique case (state_q)
                S_IDLE: if (is_k) zero_cnt_d = 3'd1;
                S_SYNC: begin
                    if (is_jk && !dec_bit && zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
                    if (is_jk && dec_bit) begin
                        ones_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                S_DATA: begin
                    if (is_se0) begin
                        error_d   = (bit_cnt_q != 3'd0);
                        bit_cnt_d = '0;
                    end else if (is_se1) begin
                        error_d = 1'b1;
                    end else if (ones_cnt_q == 3'd6) begin
                        // stuffed bit: dropped, must be a transition
                        error_d    = dec_bit;
                        ones_cnt_d = '0;
                    end else begin
                        shift_d    = {dec_bit, shift_q[7:1]};
                        ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = {dec_bit, shift_q[7:1]};
                            valid_d = 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                    if (is_se0) begin
                        se0_seen_d = 1'b1;
                        j_cnt_d    = '0;
                    end else if (is_j) begin
                        j_cnt_d = j_cnt_q + 3'd1;
                    end else begin
                        se0_seen_d = 1'b0;
                        j_cnt_d    = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync1_q    <= LS_J;
            sync2_q    <= LS_J;
            prev_q     <= LS_J;
            phase_q    <= '0;
            se0_cnt_q  <= '0;
            zero_cnt_q <= '0;
            ones_cnt_q <= '0;
            bit_cnt_q  <= '0;
            j_cnt_q    <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            se0_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            phase_q    <= phase_d;
            se0_cnt_q  <= se0_cnt_d;
            zero_cnt_q <= zero_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            j_cnt_q    <= j_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            se0_seen_q <= se0_seen_d;
        end
    end

    assign line_state = sync2_q;
    assign rx_valid   = valid_q;
    assign rx_error   = error_q;
    assign rx_data    = data_q;
    assign usb_reset  = (se0_cnt_q == RESET_MAX);

endmodule
